// File: rtl/output_collector.sv
// Captures chip output results from the shared con_* buses, tags each with its
// external-memory word address and drains them through a small FIFO to memory.
module output_collector #(
    parameter int unsigned           IO_DATA_WIDTH      = 16,
    parameter int unsigned           ACCUMULATION_WIDTH = 32,
    parameter int unsigned           FEATURE_MAP_WIDTH  = 1024,
    parameter int unsigned           FEATURE_MAP_HEIGHT = 1024,
    parameter int unsigned           OUTPUT_NB_CHANNELS = 64,
    parameter int unsigned           ADDR_WIDTH         = 32,
    parameter logic [ADDR_WIDTH-1:0] OUT_BASE_ADDR      = '0,
    parameter int unsigned           FIFO_DEPTH         = 8
) (
    input  logic                                   clk,
    input  logic                                   rst_in,
    input  logic                                   start,
    input  logic [IO_DATA_WIDTH-1:0]               con_1,
    input  logic [IO_DATA_WIDTH-1:0]               con_2,
    input  logic                                   driving_cons,
    input  logic                                   output_valid,
    input  logic [$clog2(FEATURE_MAP_WIDTH)-1:0]   output_x,
    input  logic [$clog2(FEATURE_MAP_HEIGHT)-1:0]  output_y,
    input  logic [$clog2(OUTPUT_NB_CHANNELS)-1:0]  output_ch,
    output logic                                   mem_we,
    output logic [ADDR_WIDTH-1:0]                  mem_addr,
    output logic [ACCUMULATION_WIDTH-1:0]          mem_wdata,
    input  logic                                   mem_ready,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   overflow,
    output logic [$clog2(FEATURE_MAP_WIDTH*FEATURE_MAP_HEIGHT*OUTPUT_NB_CHANNELS+1)-1:0] out_count
);

    localparam int unsigned XW    = $clog2(FEATURE_MAP_WIDTH);
    localparam int unsigned YW    = $clog2(FEATURE_MAP_HEIGHT);
    localparam int unsigned CW    = $clog2(OUTPUT_NB_CHANNELS);
    localparam int unsigned IDX_W = XW + YW + CW;
    localparam int unsigned TOTAL = FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS;
    localparam int unsigned CNT_W = $clog2(TOTAL + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(TOTAL - 1);
    localparam logic [PTR_W:0]   FULL_C = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

    state_t                        state_q;
    logic [ADDR_WIDTH-1:0]         addr_mem_q [FIFO_DEPTH];
    logic [ACCUMULATION_WIDTH-1:0] data_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]              rd_ptr_q, wr_ptr_q;
    logic [PTR_W:0]                fill_q, fill_d;
    logic [CNT_W-1:0]              out_count_q;
    logic                          overflow_q, busy_q, done_q;

    logic                  fifo_empty, fifo_full, pop, capture, push, drop, start_accept;
    logic [IDX_W-1:0]      idx;
    logic [ADDR_WIDTH-1:0] entry_addr;

    always_comb begin
        fifo_empty   = (fill_q == '0);
        fifo_full    = (fill_q == FULL_C);
        pop          = !fifo_empty && mem_ready;
        capture      = (state_q == COLLECT) && driving_cons && output_valid;
        // A full FIFO still accepts the push when the head leaves on the same edge.
        push         = capture && (!fifo_full || pop);
        drop         = capture && fifo_full && !pop;
        start_accept = (state_q == IDLE) && start;
        idx          = {output_y, output_x, output_ch};
        entry_addr   = OUT_BASE_ADDR + ADDR_WIDTH'(idx);
        fill_d       = fill_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_q     <= IDLE;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            out_count_q <= '0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            if (push) begin
                addr_mem_q[wr_ptr_q] <= entry_addr;
                data_mem_q[wr_ptr_q] <= {con_2, con_1};
            end

            if (start_accept) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                fill_q   <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                fill_q <= fill_d;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= COLLECT;
                        busy_q      <= 1'b1;
                        out_count_q <= '0;
                        overflow_q  <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (capture) begin
                        out_count_q <= out_count_q + 1'b1;
                        if (drop) overflow_q <= 1'b1;
                        if (out_count_q == LAST_C) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fill_d == '0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_we    = !fifo_empty;
    assign mem_addr  = fifo_empty ? '0 : addr_mem_q[rd_ptr_q];
    assign mem_wdata = fifo_empty ? '0 : data_mem_q[rd_ptr_q];
    assign busy      = busy_q;
    assign done      = done_q;
    assign overflow  = overflow_q;
    assign out_count = out_count_q;

endmodule

// File: tb/tb_output_collector.sv
// Bench for output_collector: fixed vector table, hand-written corner sequences
// and randomized maps, all scored against a queue-based reference model.
module tb_output_collector;

    localparam int TOTAL = 16;
    localparam int DEPTH = 4;
    localparam int P_IDLE = 0, P_COL = 1, P_DRAIN = 2, P_DONE = 3;

    logic        clk = 1'b0;
    logic        rst_in, start, driving_cons, output_valid, mem_ready;
    logic [15:0] con_1, con_2;
    logic [1:0]  output_x;
    logic [0:0]  output_y, output_ch;
    logic        mem_we, busy, done, overflow;
    logic [31:0] mem_addr, mem_wdata;
    logic [4:0]  out_count;

    always #5 clk = ~clk;

    output_collector #(
        .IO_DATA_WIDTH(16), .ACCUMULATION_WIDTH(32), .FEATURE_MAP_WIDTH(4),
        .FEATURE_MAP_HEIGHT(2), .OUTPUT_NB_CHANNELS(2), .ADDR_WIDTH(32),
        .OUT_BASE_ADDR(32'h100), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst_in(rst_in), .start(start), .con_1(con_1), .con_2(con_2),
        .driving_cons(driving_cons), .output_valid(output_valid),
        .output_x(output_x), .output_y(output_y), .output_ch(output_ch),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .busy(busy), .done(done), .overflow(overflow),
        .out_count(out_count)
    );

    typedef struct packed {logic [31:0] addr; logic [31:0] data;} wr_t;

    typedef struct {
        bit st, dc, ov; logic [1:0] x; logic y, ch; logic [31:0] dat; bit rdy;
        bit we; logic [31:0] addr, data; int cnt; bit bsy, ovf;
    } vec_t;

    wr_t  mq[$];
    wr_t  wlog[$];
    int   m_phase, m_cnt;
    bit   m_ovf, model_valid;
    int   checks, failures, done_pulses;
    vec_t tv[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle(input bit rs, input bit st, input bit d, input bit v,
                         input logic [1:0] x, input logic y, input logic ch,
                         input logic [31:0] dat, input bit rdy);
        bit  pop;
        wr_t e;
        rst_in = rs; start = st; driving_cons = d; output_valid = v;
        output_x = x; output_y = y; output_ch = ch;
        con_2 = dat[31:16]; con_1 = dat[15:0]; mem_ready = rdy;
        #1;
        if (model_valid && !rs) begin
            check("mem_we", {63'd0, mem_we}, {63'd0, mq.size() != 0});
            if (mq.size() != 0) begin
                check("mem_addr", {32'd0, mem_addr}, {32'd0, mq[0].addr});
                check("mem_wdata", {32'd0, mem_wdata}, {32'd0, mq[0].data});
            end
        end
        if (!rs && mem_we === 1'b1 && rdy) wlog.push_back({mem_addr, mem_wdata});

        if (rs) begin
            mq.delete(); m_cnt = 0; m_ovf = 0; m_phase = P_IDLE; model_valid = 1;
        end else if (m_phase == P_IDLE && st) begin
            mq.delete(); m_cnt = 0; m_ovf = 0; m_phase = P_COL;
        end else begin
            pop = (mq.size() != 0) && rdy;
            if (pop) void'(mq.pop_front());
            case (m_phase)
                P_COL: if (d && v) begin
                    m_cnt++;
                    e.addr = 32'h100 + 8 * int'(y) + 2 * int'(x) + int'(ch);
                    e.data = dat;
                    if (mq.size() < DEPTH) mq.push_back(e);
                    else m_ovf = 1;
                    if (m_cnt == TOTAL) m_phase = P_DRAIN;
                end
                P_DRAIN: if (mq.size() == 0) m_phase = P_DONE;
                P_DONE:  m_phase = P_IDLE;
                default: ;
            endcase
        end

        @(posedge clk);
        @(negedge clk);
        if (done === 1'b1) done_pulses++;
        if (model_valid) begin
            check("busy", {63'd0, busy}, {63'd0, m_phase != P_IDLE});
            check("done", {63'd0, done}, {63'd0, m_phase == P_DONE});
            check("overflow", {63'd0, overflow}, {63'd0, m_ovf});
            check("out_count", {59'd0, out_count}, 64'(m_cnt));
        end
    endtask

    task automatic idle(input bit rdy);
        cycle(0, 0, 0, 0, 2'd0, 1'b0, 1'b0, 32'd0, rdy);
    endtask

    task automatic do_start();
        cycle(0, 1, 0, 0, 2'd0, 1'b0, 1'b0, 32'd0, 1);
    endtask

    // Index i walks the map as ch = bit0, x = bits2:1, y = bit3.
    task automatic ev_idx(input int i, input logic [31:0] dat, input bit rdy);
        logic [3:0] b;
        b = i[3:0];
        cycle(0, 0, 1, 1, b[2:1], b[3], b[0], dat, rdy);
    endtask

    task automatic wait_done(input int budget);
        int n;
        int d0;
        n = 0;
        d0 = done_pulses;
        while (done_pulses == d0 && n < budget) begin
            idle(1);
            n++;
        end
        checks++;
        if (done_pulses == d0) begin
            failures++;
            $display("FAIL done_timeout: no done within %0d cycles", budget);
        end
        idle(1);
        idle(1);
        check("done_once", 64'(done_pulses - d0), 64'd1);
    endtask

    task automatic random_map();
        int n;
        int d0;
        logic [31:0] r;
        n = 0;
        d0 = done_pulses;
        do_start();
        while (done_pulses == d0 && n < 400) begin
            r = $urandom;
            cycle(0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) != 0, r[1:0], r[2], r[3], $urandom,
                  $urandom_range(0, 2) != 0);
            n++;
        end
        checks++;
        if (done_pulses == d0) begin
            failures++;
            $display("FAIL rand_timeout: no done within 400 cycles");
        end
        idle(1);
        idle(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0; done_pulses = 0; model_valid = 0; m_phase = P_IDLE;
        rst_in = 1; start = 0; driving_cons = 0; output_valid = 0; mem_ready = 0;
        con_1 = '0; con_2 = '0; output_x = '0; output_y = '0; output_ch = '0;

        //          st dc ov x     y     ch    dat           rdy we addr       data          cnt bsy ovf
        tv[0] = '{1, 0, 0, 2'd0, 1'b0, 1'b0, 32'h0,        1, 0, 32'h0,     32'h0,        0, 1, 0};
        tv[1] = '{0, 1, 1, 2'd1, 1'b0, 1'b0, 32'hDEADBEEF, 0, 1, 32'h102,   32'hDEADBEEF, 1, 1, 0};
        tv[2] = '{0, 0, 1, 2'd0, 1'b0, 1'b0, 32'h12345678, 0, 1, 32'h102,   32'hDEADBEEF, 1, 1, 0};
        tv[3] = '{1, 0, 0, 2'd0, 1'b0, 1'b0, 32'h0,        1, 0, 32'h0,     32'h0,        1, 1, 0};
        tv[4] = '{0, 1, 0, 2'd3, 1'b1, 1'b1, 32'h55555555, 1, 0, 32'h0,     32'h0,        1, 1, 0};

        @(negedge clk);
        cycle(1, 0, 0, 0, 2'd0, 1'b0, 1'b0, 32'd0, 1);
        cycle(1, 0, 0, 0, 2'd0, 1'b0, 1'b0, 32'd0, 1);
        check("rst_we", {63'd0, mem_we}, 64'd0);
        check("rst_addr", {32'd0, mem_addr}, 64'd0);
        check("rst_wdata", {32'd0, mem_wdata}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_cnt", {59'd0, out_count}, 64'd0);

        // Latency, filtering and start-ignored-in-COLLECT vectors.
        for (int k = 0; k < 5; k++) begin
            cycle(0, tv[k].st, tv[k].dc, tv[k].ov, tv[k].x, tv[k].y, tv[k].ch, tv[k].dat, tv[k].rdy);
            check($sformatf("tv%0d_we", k), {63'd0, mem_we}, {63'd0, tv[k].we});
            if (tv[k].we) begin
                check($sformatf("tv%0d_addr", k), {32'd0, mem_addr}, {32'd0, tv[k].addr});
                check($sformatf("tv%0d_data", k), {32'd0, mem_wdata}, {32'd0, tv[k].data});
            end
            check($sformatf("tv%0d_cnt", k), {59'd0, out_count}, 64'(tv[k].cnt));
            check($sformatf("tv%0d_busy", k), {63'd0, busy}, {63'd0, tv[k].bsy});
            check($sformatf("tv%0d_ovf", k), {63'd0, overflow}, {63'd0, tv[k].ovf});
        end
        for (int i = 1; i < 16; i++) ev_idx(i, $urandom, 1);
        wait_done(20);

        // Basic: full map in order, data = index.
        do_start();
        wlog.delete();
        for (int i = 0; i < 16; i++) ev_idx(i, 32'(i), 1);
        wait_done(20);
        check("basic_nwr", 64'(wlog.size()), 64'd16);
        for (int i = 0; i < wlog.size(); i++) begin
            check($sformatf("basic_addr%0d", i), {32'd0, wlog[i].addr}, 64'(32'h100 + i));
            check($sformatf("basic_data%0d", i), {32'd0, wlog[i].data}, 64'(i));
        end
        check("basic_ovf", {63'd0, overflow}, 64'd0);
        check("basic_busy", {63'd0, busy}, 64'd0);

        // Backpressure with one dropped entry.
        do_start();
        for (int i = 0; i < 4; i++) ev_idx(i, 32'hA0 + 32'(i), 0);
        check("bp_we", {63'd0, mem_we}, 64'd1);
        check("bp_head_addr", {32'd0, mem_addr}, 64'h100);
        check("bp_head_data", {32'd0, mem_wdata}, 64'hA0);
        ev_idx(4, 32'hA4, 0);
        check("bp_ovf", {63'd0, overflow}, 64'd1);
        check("bp_cnt", {59'd0, out_count}, 64'd5);
        wlog.delete();
        repeat (8) idle(1);
        check("bp_nwr", 64'(wlog.size()), 64'd4);
        for (int i = 5; i < 16; i++) ev_idx(i, $urandom, 1);
        wait_done(20);
        check("bp_ovf_sticky", {63'd0, overflow}, 64'd1);

        // Full FIFO with a pop on the same edge as the push.
        do_start();
        check("fp_ovf_clr", {63'd0, overflow}, 64'd0);
        wlog.delete();
        for (int i = 0; i < 4; i++) ev_idx(i, 32'hC0 + 32'(i), 0);
        ev_idx(4, 32'hC4, 1);
        check("fp_ovf", {63'd0, overflow}, 64'd0);
        for (int i = 5; i < 16; i++) ev_idx(i, 32'hC0 + 32'(i), 1);
        wait_done(20);
        check("fp_nwr", 64'(wlog.size()), 64'd16);
        if (wlog.size() > 4) check("fp_entry4", {32'd0, wlog[4].data}, 64'hC4);
        check("fp_ovf_end", {63'd0, overflow}, 64'd0);

        repeat (3) random_map();

        // Reset mid-COLLECT after 7 events, 3 still buffered.
        do_start();
        for (int i = 0; i < 5; i++) ev_idx(i, 32'(i), 1);
        for (int i = 5; i < 7; i++) ev_idx(i, 32'(i), 0);
        check("mr_we_pre", {63'd0, mem_we}, 64'd1);
        cycle(1, 0, 0, 0, 2'd0, 1'b0, 1'b0, 32'd0, 1);
        check("mr_we", {63'd0, mem_we}, 64'd0);
        check("mr_addr", {32'd0, mem_addr}, 64'd0);
        check("mr_wdata", {32'd0, mem_wdata}, 64'd0);
        check("mr_busy", {63'd0, busy}, 64'd0);
        check("mr_done", {63'd0, done}, 64'd0);
        check("mr_ovf", {63'd0, overflow}, 64'd0);
        check("mr_cnt", {59'd0, out_count}, 64'd0);
        wlog.delete();
        repeat (5) idle(1);
        check("mr_nwr", 64'(wlog.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
